kernel_recv_frame: RTL and testbench

// Receive-side frame parser for the GTP board-to-board link; counterpart of the kernel transmit path. Decodes 32-bit GTP

---
 rtl/kernel_recv_frame.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_kernel_recv_frame.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/kernel_recv_frame.sv
// GTP receive-side frame parser: K-char words -> 64-bit payload writes, status/send-back/info messages.
// Latency: 1 cycle, all outputs registered. No backpressure: a write while rx_full is dropped and flagged.
module kernel_recv_frame #(
  parameter int MAX_BURST = 16,
  parameter int ALIGN_CNT = 8,
  parameter int ERR_LIMIT = 4,
  parameter int CNT_W     = 16
) (
  input  logic             rx_clk,
  input  logic             ap_rst_n,
  input  logic [31:0]      gtp_rxdata,
  input  logic [3:0]       gtp_rxctl,
  input  logic             rx_full,
  output logic             rx_wr_en,
  output logic [63:0]      rx_wr_data,
  output logic             rx_frame_end,
  output logic             rx_frame_ok,
  output logic             buff_statue_vaild,
  output logic [31:0]      buff_statue,
  output logic             recv_back_flag,
  output logic [15:0]      recv_back_data,
  output logic             recv_info_vaild,
  output logic [15:0]      recv_info,
  output logic             lane_up,
  output logic             frame_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int LEN_W = $clog2(MAX_BURST + 1);
  localparam int AL_W  = $clog2(ALIGN_CNT + 1);
  localparam int ER_W  = $clog2(ERR_LIMIT + 1);

  localparam logic [15:0] MAX_LEN = 16'(MAX_BURST);
  localparam logic [7:0]  K_IDLE  = 8'hBC;
  localparam logic [7:0]  K_SOF   = 8'hFB;
  localparam logic [7:0]  K_EOF   = 8'hFD;
  localparam logic [7:0]  T_DATA  = 8'h01;
  localparam logic [7:0]  T_STAT  = 8'h02;
  localparam logic [7:0]  T_BACK  = 8'h03;
  localparam logic [7:0]  T_INFO  = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_STAT = 3'd1,
    S_DLO  = 3'd2,
    S_DHI  = 3'd3,
    S_EOF  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [15:0]       csum_q, csum_d;
  logic [31:0]       lo_q, lo_d;
  logic              ovf_q, ovf_d;
  logic [AL_W-1:0]   align_q, align_d;
  logic [ER_W-1:0]   errrun_q, errrun_d;
  logic              lane_d;

  logic              wr_en_d, fend_d, fok_d, bs_vld_d, back_vld_d, info_vld_d, err_d;
  logic [63:0]       wr_data_d;
  logic [31:0]       bs_d;
  logic [15:0]       back_d, info_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              reproc;

  // Word decode
  logic        is_data, is_ctl, is_idle, is_sof, is_eof, is_msg, bad_word, frame_act;
  logic [7:0]  typ;
  logic [15:0] arg, word_fold;

  assign typ       = gtp_rxdata[15:8];
  assign arg       = gtp_rxdata[31:16];
  assign word_fold = gtp_rxdata[31:16] ^ gtp_rxdata[15:0];
  assign is_data   = (gtp_rxctl == 4'b0000);
  assign is_ctl    = (gtp_rxctl == 4'b0001);
  assign is_idle   = is_ctl && (gtp_rxdata[7:0] == K_IDLE);
  assign is_sof    = is_ctl && (gtp_rxdata[7:0] == K_SOF);
  assign is_eof    = is_ctl && (gtp_rxdata[7:0] == K_EOF);
  assign is_msg    = is_sof && ((typ == T_BACK) || (typ == T_INFO));
  assign bad_word  = !(is_data || is_ctl)
                   || (is_ctl && !is_idle && !is_sof && !is_eof)
                   || (is_sof && !((typ == T_DATA) || (typ == T_STAT) || (typ == T_BACK) || (typ == T_INFO)));
  assign frame_act = (state_q == S_DLO) || (state_q == S_DHI) || (state_q == S_EOF);

  always_ff @(posedge rx_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q           <= S_IDLE;
      len_q             <= '0;
      csum_q            <= '0;
      lo_q              <= '0;
      ovf_q             <= 1'b0;
      align_q           <= '0;
      errrun_q          <= '0;
      lane_up           <= 1'b0;
      rx_wr_en          <= 1'b0;
      rx_wr_data        <= '0;
      rx_frame_end      <= 1'b0;
      rx_frame_ok       <= 1'b0;
      buff_statue_vaild <= 1'b0;
      buff_statue       <= '0;
      recv_back_flag    <= 1'b0;
      recv_back_data    <= '0;
      recv_info_vaild   <= 1'b0;
      recv_info         <= '0;
      frame_err         <= 1'b0;
      err_cnt           <= '0;
    end else begin
      state_q           <= state_d;
      len_q             <= len_d;
      csum_q            <= csum_d;
      lo_q              <= lo_d;
      ovf_q             <= ovf_d;
      align_q           <= align_d;
      errrun_q          <= errrun_d;
      lane_up           <= lane_d;
      rx_wr_en          <= wr_en_d;
      rx_wr_data        <= wr_data_d;
      rx_frame_end      <= fend_d;
      rx_frame_ok       <= fok_d;
      buff_statue_vaild <= bs_vld_d;
      buff_statue       <= bs_d;
      recv_back_flag    <= back_vld_d;
      recv_back_data    <= back_d;
      recv_info_vaild   <= info_vld_d;
      recv_info         <= info_d;
      frame_err         <= err_d;
      err_cnt           <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    csum_d     = csum_q;
    lo_d       = lo_q;
    ovf_d      = ovf_q;
    align_d    = align_q;
    errrun_d   = errrun_q;
    lane_d     = lane_up;
    wr_en_d    = 1'b0;
    wr_data_d  = rx_wr_data;
    fend_d     = 1'b0;
    fok_d      = 1'b0;
    bs_vld_d   = 1'b0;
    bs_d       = buff_statue;
    back_vld_d = 1'b0;
    back_d     = recv_back_data;
    info_vld_d = 1'b0;
    info_d     = recv_info;
    err_d      = 1'b0;
    cnt_d      = err_cnt;
    reproc     = 1'b0;

    if (!lane_up) begin
      // Lane down: only a run of IDLEs matters, everything else restarts the run silently.
      if (is_idle) begin
        if (align_q == AL_W'(ALIGN_CNT - 1)) begin
          lane_d  = 1'b1;
          align_d = '0;
        end else begin
          align_d = align_q + AL_W'(1);
        end
      end else begin
        align_d = '0;
      end
    end else if (!is_idle) begin
      if (bad_word) begin
        err_d   = 1'b1;
        fend_d  = frame_act;
        state_d = S_IDLE;
      end else if (is_msg) begin
        if (typ == T_BACK) begin
          back_vld_d = 1'b1;
          back_d     = arg;
        end else begin
          info_vld_d = 1'b1;
          info_d     = arg;
        end
      end else begin
        case (state_q)
          S_IDLE: reproc = 1'b1;
          S_STAT: begin
            if (is_data) begin
              bs_vld_d = 1'b1;
              bs_d     = gtp_rxdata;
              state_d  = S_IDLE;
            end else begin
              err_d  = 1'b1;
              reproc = 1'b1;
            end
          end
          S_DLO: begin
            if (is_data) begin
              lo_d    = gtp_rxdata;
              csum_d  = csum_q ^ word_fold;
              state_d = S_DHI;
            end else begin
              err_d   = 1'b1;
              fend_d  = 1'b1;
              state_d = S_IDLE;
              reproc  = is_sof;
            end
          end
          S_DHI: begin
            if (is_data) begin
              csum_d = csum_q ^ word_fold;
              if (rx_full) begin
                err_d = !ovf_q;
                ovf_d = 1'b1;
              end else begin
                wr_en_d   = 1'b1;
                wr_data_d = {gtp_rxdata, lo_q};
              end
              len_d   = len_q - LEN_W'(1);
              state_d = (len_q == LEN_W'(1)) ? S_EOF : S_DLO;
            end else begin
              err_d   = 1'b1;
              fend_d  = 1'b1;
              state_d = S_IDLE;
              reproc  = is_sof;
            end
          end
          S_EOF: begin
            fend_d  = 1'b1;
            state_d = S_IDLE;
            if (is_eof) begin
              fok_d = (csum_q == arg) && !ovf_q;
              err_d = (csum_q != arg);
            end else begin
              err_d  = 1'b1;
              reproc = is_sof;
            end
          end
          default: state_d = S_IDLE;
        endcase

        // Word handled as if no frame were open (fresh SOF, stray EOF, stray data).
        if (reproc) begin
          state_d = S_IDLE;
          if (is_sof && (typ == T_DATA)) begin
            if ((arg != 16'd0) && (arg <= MAX_LEN)) begin
              state_d = S_DLO;
              len_d   = LEN_W'(arg);
              csum_d  = '0;
              ovf_d   = 1'b0;
            end else begin
              err_d = 1'b1;
            end
          end else if (is_sof && (typ == T_STAT)) begin
            state_d = S_STAT;
          end else if (is_eof) begin
            err_d = 1'b1;
          end
        end
      end

      if (err_d) begin
        if (errrun_q == ER_W'(ERR_LIMIT - 1)) begin
          lane_d   = 1'b0;
          errrun_d = '0;
          align_d  = '0;
          if ((state_d == S_DLO) || (state_d == S_DHI) || (state_d == S_EOF)) begin
            fend_d = 1'b1;
            fok_d  = 1'b0;
          end
          state_d = S_IDLE;
        end else begin
          errrun_d = errrun_q + ER_W'(1);
        end
      end else begin
        errrun_d = '0;
      end
    end

    if (err_d && (err_cnt != {CNT_W{1'b1}})) begin
      cnt_d = err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_kernel_recv_frame.sv
// Directed bench for kernel_recv_frame: vector table for the frame sequences, hand sequences for reset and lane drop.
module tb_kernel_recv_frame;

  logic        rx_clk;
  logic        ap_rst_n;
  logic [31:0] gtp_rxdata;
  logic [3:0]  gtp_rxctl;
  logic        rx_full;
  logic        rx_wr_en;
  logic [63:0] rx_wr_data;
  logic        rx_frame_end;
  logic        rx_frame_ok;
  logic        buff_statue_vaild;
  logic [31:0] buff_statue;
  logic        recv_back_flag;
  logic [15:0] recv_back_data;
  logic        recv_info_vaild;
  logic [15:0] recv_info;
  logic        lane_up;
  logic        frame_err;
  logic [15:0] err_cnt;

  kernel_recv_frame dut (
    .rx_clk            (rx_clk),
    .ap_rst_n          (ap_rst_n),
    .gtp_rxdata        (gtp_rxdata),
    .gtp_rxctl         (gtp_rxctl),
    .rx_full           (rx_full),
    .rx_wr_en          (rx_wr_en),
    .rx_wr_data        (rx_wr_data),
    .rx_frame_end      (rx_frame_end),
    .rx_frame_ok       (rx_frame_ok),
    .buff_statue_vaild (buff_statue_vaild),
    .buff_statue       (buff_statue),
    .recv_back_flag    (recv_back_flag),
    .recv_back_data    (recv_back_data),
    .recv_info_vaild   (recv_info_vaild),
    .recv_info         (recv_info),
    .lane_up           (lane_up),
    .frame_err         (frame_err),
    .err_cnt           (err_cnt)
  );

  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  localparam logic [3:0]  KC     = 4'b0001;
  localparam logic [3:0]  DC     = 4'b0000;
  localparam logic [31:0] IDLE_W = 32'h0000_00BC;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  ctl;
    logic        full;
    logic        wr;
    logic [63:0] wdat;
    logic        fend;
    logic        fok;
    logic        ferr;
    logic        lane;
    logic [15:0] ecnt;
    logic        svld;
    logic        ivld;
    logic        bvld;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] sof(input logic [7:0] t, input logic [15:0] a);
    return {a, t, 8'hFB};
  endfunction

  function automatic logic [31:0] eof(input logic [15:0] c);
    return {c, 8'h00, 8'hFD};
  endfunction

  task automatic add(input logic [31:0] d, input logic [3:0] ctl, input logic full,
                     input logic wr, input logic [63:0] wdat,
                     input logic fend, input logic fok, input logic ferr, input logic lane,
                     input logic [15:0] ecnt, input logic svld, input logic ivld, input logic bvld);
    vec_t v;
    v.d = d; v.ctl = ctl; v.full = full; v.wr = wr; v.wdat = wdat;
    v.fend = fend; v.fok = fok; v.ferr = ferr; v.lane = lane; v.ecnt = ecnt;
    v.svld = svld; v.ivld = ivld; v.bvld = bvld;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one word, then look at the registered result just after the edge.
  task automatic send(input logic [31:0] d, input logic [3:0] ctl, input logic full);
    gtp_rxdata = d;
    gtp_rxctl  = ctl;
    rx_full    = full;
    @(posedge rx_clk);
    #1;
  endtask

  function automatic logic [63:0] flags();
    return {40'd0, rx_wr_en, rx_frame_end, rx_frame_ok, frame_err, lane_up,
            buff_statue_vaild, recv_info_vaild, recv_back_flag, err_cnt};
  endfunction

  initial begin
    logic [63:0] exp_f;

    // Link alignment: a data word breaks the IDLE run
    for (int i = 0; i < 7; i++) add(IDLE_W, KC, 0, 0, 0, 0, 0, 0, 0, 16'd0, 0, 0, 0);
    add(32'h1234_5678, DC, 0, 0, 0, 0, 0, 0, 0, 16'd0, 0, 0, 0);
    for (int i = 0; i < 7; i++) add(IDLE_W, KC, 0, 0, 0, 0, 0, 0, 0, 16'd0, 0, 0, 0);
    add(IDLE_W, KC, 0, 0, 0, 0, 0, 0, 1, 16'd0, 0, 0, 0);
    // Good one-word frame
    add(sof(8'h01, 16'd1),  KC, 0, 0, 0, 0, 0, 0, 1, 16'd0, 0, 0, 0);
    add(32'h1,              DC, 0, 0, 0, 0, 0, 0, 1, 16'd0, 0, 0, 0);
    add(32'h2,              DC, 0, 1, 64'h00000002_00000001, 0, 0, 0, 1, 16'd0, 0, 0, 0);
    add(eof(16'h0003),      KC, 0, 0, 0, 1, 1, 0, 1, 16'd0, 0, 0, 0);
    // Checksum mismatch
    add(sof(8'h01, 16'd1),  KC, 0, 0, 0, 0, 0, 0, 1, 16'd0, 0, 0, 0);
    add(32'h1,              DC, 0, 0, 0, 0, 0, 0, 1, 16'd0, 0, 0, 0);
    add(32'h2,              DC, 0, 1, 64'h00000002_00000001, 0, 0, 0, 1, 16'd0, 0, 0, 0);
    add(eof(16'h0004),      KC, 0, 0, 0, 1, 0, 1, 1, 16'd1, 0, 0, 0);
    // Status message, then info message and clock-correction IDLE inside a len-2 frame
    add(sof(8'h02, 16'd0),  KC, 0, 0, 0, 0, 0, 0, 1, 16'd1, 0, 0, 0);
    add(32'hA5A5_0F0F,      DC, 0, 0, 0, 0, 0, 0, 1, 16'd1, 1, 0, 0);
    add(sof(8'h01, 16'd2),  KC, 0, 0, 0, 0, 0, 0, 1, 16'd1, 0, 0, 0);
    add(32'h11,             DC, 0, 0, 0, 0, 0, 0, 1, 16'd1, 0, 0, 0);
    add(32'h22,             DC, 0, 1, 64'h00000022_00000011, 0, 0, 0, 1, 16'd1, 0, 0, 0);
    add(sof(8'h04, 16'h1234), KC, 0, 0, 0, 0, 0, 0, 1, 16'd1, 0, 1, 0);
    add(32'h44,             DC, 0, 0, 0, 0, 0, 0, 1, 16'd1, 0, 0, 0);
    add(IDLE_W,             KC, 0, 0, 0, 0, 0, 0, 1, 16'd1, 0, 0, 0);
    add(32'h88,             DC, 0, 1, 64'h00000088_00000044, 0, 0, 0, 1, 16'd1, 0, 0, 0);
    add(eof(16'h00FF),      KC, 0, 0, 0, 1, 1, 0, 1, 16'd1, 0, 0, 0);
    // Overflow on 2nd of 3 payload words: dropped, flagged once, frame not ok
    add(sof(8'h01, 16'd3),  KC, 0, 0, 0, 0, 0, 0, 1, 16'd1, 0, 0, 0);
    add(32'h1,              DC, 0, 0, 0, 0, 0, 0, 1, 16'd1, 0, 0, 0);
    add(32'h2,              DC, 0, 1, 64'h00000002_00000001, 0, 0, 0, 1, 16'd1, 0, 0, 0);
    add(32'h3,              DC, 0, 0, 0, 0, 0, 0, 1, 16'd1, 0, 0, 0);
    add(32'h4,              DC, 1, 0, 0, 0, 0, 1, 1, 16'd2, 0, 0, 0);
    add(32'h5,              DC, 0, 0, 0, 0, 0, 0, 1, 16'd2, 0, 0, 0);
    add(32'h6,              DC, 0, 1, 64'h00000006_00000005, 0, 0, 0, 1, 16'd2, 0, 0, 0);
    add(eof(16'h0007),      KC, 0, 0, 0, 1, 0, 0, 1, 16'd2, 0, 0, 0);
    // SOF mid-frame aborts and opens the new frame in the same cycle
    add(sof(8'h01, 16'd2),  KC, 0, 0, 0, 0, 0, 0, 1, 16'd2, 0, 0, 0);
    add(32'h7,              DC, 0, 0, 0, 0, 0, 0, 1, 16'd2, 0, 0, 0);
    add(32'h8,              DC, 0, 1, 64'h00000008_00000007, 0, 0, 0, 1, 16'd2, 0, 0, 0);
    add(sof(8'h01, 16'd1),  KC, 0, 0, 0, 1, 0, 1, 1, 16'd3, 0, 0, 0);
    add(32'h9,              DC, 0, 0, 0, 0, 0, 0, 1, 16'd3, 0, 0, 0);
    add(32'hA,              DC, 0, 1, 64'h0000000A_00000009, 0, 0, 0, 1, 16'd3, 0, 0, 0);
    add(eof(16'h0003),      KC, 0, 0, 0, 1, 1, 0, 1, 16'd3, 0, 0, 0);
    // Unknown type and out-of-range lengths; three errors in a row keep the lane up
    add(sof(8'h05, 16'd0),  KC, 0, 0, 0, 0, 0, 1, 1, 16'd4, 0, 0, 0);
    add(sof(8'h01, 16'd0),  KC, 0, 0, 0, 0, 0, 1, 1, 16'd5, 0, 0, 0);
    add(sof(8'h01, 16'd17), KC, 0, 0, 0, 0, 0, 1, 1, 16'd6, 0, 0, 0);
    add(sof(8'h03, 16'hABCD), KC, 0, 0, 0, 0, 0, 0, 1, 16'd6, 0, 0, 1);

    gtp_rxdata = '0;
    gtp_rxctl  = '0;
    rx_full    = 1'b0;
    ap_rst_n   = 1'b0;
    repeat (3) @(posedge rx_clk);
    #1;
    check("reset_flags", flags(), 64'd0);
    check("reset_held", {buff_statue, recv_back_data, recv_info}, 64'd0);
    check("reset_wdata", rx_wr_data, 64'd0);
    @(negedge rx_clk);
    ap_rst_n = 1'b1;

    foreach (vecs[i]) begin
      send(vecs[i].d, vecs[i].ctl, vecs[i].full);
      exp_f = {40'd0, vecs[i].wr, vecs[i].fend, vecs[i].fok, vecs[i].ferr, vecs[i].lane,
               vecs[i].svld, vecs[i].ivld, vecs[i].bvld, vecs[i].ecnt};
      check($sformatf("vec%0d_flags", i), flags(), exp_f);
      if (vecs[i].wr) check($sformatf("vec%0d_wdata", i), rx_wr_data, vecs[i].wdat);
    end

    check("held_status", {32'd0, buff_statue}, 64'h0000_0000_A5A5_0F0F);
    check("held_info", {48'd0, recv_info}, 64'h1234);
    check("held_back", {48'd0, recv_back_data}, 64'hABCD);

    // Reset in the middle of a frame clears everything and the partial frame never ends
    send(sof(8'h01, 16'd1), KC, 0);
    send(32'h1, DC, 0);
    ap_rst_n = 1'b0;
    #1;
    check("midrst_flags", flags(), 64'd0);
    check("midrst_held", {buff_statue, recv_back_data, recv_info}, 64'd0);
    check("midrst_wdata", rx_wr_data, 64'd0);
    send(32'h2, DC, 0);
    ap_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) send(IDLE_W, KC, 0);
    check("realign", flags(), {40'd0, 8'b0000_1000, 16'd0});
    send(32'h2, DC, 0);
    check("no_stale_write", flags(), {40'd0, 8'b0000_1000, 16'd0});

    // Illegal K flags while up: lane drops on the 4th consecutive error
    for (int i = 0; i < 4; i++) begin
      send(32'h0, 4'b0010, 0);
      check($sformatf("illegal%0d", i), {45'd0, frame_err, lane_up, err_cnt},
            {45'd0, 1'b1, (i < 3), 16'(i + 1)});
    end
    send(32'h0, 4'b0010, 0);
    check("down_ignores", {45'd0, frame_err, lane_up, err_cnt}, {45'd0, 1'b0, 1'b0, 16'd4});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
